la_rx_readback: RTL and testbench

Receive-path readback block for the AMSAT TX/RX user project. It is the outbound counterpart of the logic-analyzer configuration inputs. It captures words strobed out of the receiver digital datapath into a small FIFO. It presents them one at a time to the management SoC over logic-analyzer outputs, using a toggle request/acknowledge handshake that firmware drives through a logic-analyzer input bit.

---
 rtl/la_rx_readback_if.sv | 40 ++++
 rtl/la_rx_readback.sv | 146 ++++++++++++++
 tb/tb_la_rx_readback.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/la_rx_readback_if.sv
// Bus bundle between the receiver readback block and its logic-analyzer side.
// RB_TIMESTAMP_EN adds the TS_W parameter and the rd_tstamp signal.
interface la_rx_readback_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
`ifdef RB_TIMESTAMP_EN
  , parameter int TS_W   = 16
`endif
);
    logic [DATA_W-1:0]        rx_data;
    logic                     rx_valid;
    logic                     la_ack_tgl;
    logic                     la_clr_ovf;
    logic [DATA_W-1:0]        rd_data;
    logic                     rd_req_tgl;
    logic [$clog2(DEPTH):0]   fill_level;
    logic                     empty;
    logic                     overflow;
`ifdef RB_TIMESTAMP_EN
    logic [TS_W-1:0]          rd_tstamp;

    modport master (
        output rx_data, rx_valid, la_ack_tgl, la_clr_ovf,
        input  rd_data, rd_req_tgl, fill_level, empty, overflow, rd_tstamp
    );
    modport slave (
        input  rx_data, rx_valid, la_ack_tgl, la_clr_ovf,
        output rd_data, rd_req_tgl, fill_level, empty, overflow, rd_tstamp
    );
`else
    modport master (
        output rx_data, rx_valid, la_ack_tgl, la_clr_ovf,
        input  rd_data, rd_req_tgl, fill_level, empty, overflow
    );
    modport slave (
        input  rx_data, rx_valid, la_ack_tgl, la_clr_ovf,
        output rd_data, rd_req_tgl, fill_level, empty, overflow
    );
`endif
endinterface

// File: rtl/la_rx_readback.sv
// Receive-path readback: captures rx words into a FIFO and presents them one at a
// time over a toggle req/ack handshake. Define RB_TIMESTAMP_EN to tag words with a timestamp.
module la_rx_readback #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int TS_W   = 16
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n,
    la_rx_readback_if.slave bus
);
`ifdef RB_TIMESTAMP_EN
    localparam int TS_USED = TS_W;
`else
    localparam int TS_USED = 0;
`endif
    localparam int FW = DATA_W + TS_USED;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, PRESENT} state_e;

    state_e            state_q, state_d;
    logic              ack_meta_q, ack_meta_d;
    logic              ack_s_q, ack_s_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              req_q, req_d;
    logic              ovf_q, ovf_d;
    logic [FW-1:0]     mem_q [DEPTH];
    logic [FW-1:0]     wr_word;
    logic [FW-1:0]     head_word;
    logic              full, pop, push, drop;
`ifdef RB_TIMESTAMP_EN
    logic [TS_W-1:0]   ts_cnt_q, ts_cnt_d;
    logic [TS_W-1:0]   rd_ts_q, rd_ts_d;
`endif

`ifdef RB_TIMESTAMP_EN
    assign wr_word = {ts_cnt_q, bus.rx_data};
`else
    assign wr_word = bus.rx_data;
`endif
    assign head_word = mem_q[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        ack_meta_d = bus.la_ack_tgl;
        ack_s_d    = ack_meta_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        req_d      = req_q;
        ovf_d      = ovf_q;
`ifdef RB_TIMESTAMP_EN
        ts_cnt_d   = ts_cnt_q + TS_W'(1);
        rd_ts_d    = rd_ts_q;
`endif
        full = (count_q == CW'(DEPTH));
        // Host is ready for another word when nothing is on display or it acked the last one.
        pop  = (count_q != '0) && ((state_q == IDLE) || (ack_s_q == req_q));
        // A pop on the same edge frees the slot a full FIFO needs for the incoming word.
        push = bus.rx_valid && (!full || pop);
        drop = bus.rx_valid && full && !pop;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + AW'(1);
            rd_data_d = head_word[DATA_W-1:0];
            req_d     = ~req_q;
`ifdef RB_TIMESTAMP_EN
            rd_ts_d   = head_word[FW-1:DATA_W];
`endif
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.la_clr_ovf) begin
            ovf_d = 1'b0;
        end

        case (state_q)
            IDLE:    if (pop) state_d = PRESENT;
            PRESENT: if ((ack_s_q == req_q) && (count_q == '0)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q    <= IDLE;
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            req_q      <= 1'b0;
            ovf_q      <= 1'b0;
`ifdef RB_TIMESTAMP_EN
            ts_cnt_q   <= '0;
            rd_ts_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ack_meta_q <= ack_meta_d;
            ack_s_q    <= ack_s_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            req_q      <= req_d;
            ovf_q      <= ovf_d;
`ifdef RB_TIMESTAMP_EN
            ts_cnt_q   <= ts_cnt_d;
            rd_ts_q    <= rd_ts_d;
`endif
        end
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_word;
        end
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_req_tgl = req_q;
    assign bus.fill_level = count_q;
    assign bus.empty      = (count_q == '0);
    assign bus.overflow   = ovf_q;
`ifdef RB_TIMESTAMP_EN
    assign bus.rd_tstamp  = rd_ts_q;
`endif
endmodule

// File: tb/tb_la_rx_readback.sv
// Bench for la_rx_readback: hand-derived vector table, directed corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_la_rx_readback;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int TS_W   = 16;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

`ifdef RB_TIMESTAMP_EN
    la_rx_readback_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)) bus ();
`else
    la_rx_readback_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
`endif

    la_rx_readback #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .wb_clk_i (clk),
        .wb_rst_n (rst_n),
        .bus      (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic host_ack = 1'b0;

    // Reference model: queue of {timestamp, word}, the word on display, and the host-side sync delay line.
    logic [TS_W+DATA_W-1:0] mq [$];
    logic [DATA_W-1:0] m_rd;
    logic [TS_W-1:0]   m_ts, m_cnt;
    logic m_req, m_busy, m_ovf, m_s1, m_s2;

    function automatic void model_reset();
        mq.delete();
        m_rd = '0; m_ts = '0; m_cnt = '0;
        m_req = 1'b0; m_busy = 1'b0; m_ovf = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
    endfunction

    function automatic void model_edge(logic v, logic [DATA_W-1:0] d, logic a, logic c);
        logic ready;
        logic accept;
        ready = !m_busy || (m_s2 == m_req);
        if (ready && mq.size() > 0) begin
            {m_ts, m_rd} = mq.pop_front();
            m_req  = ~m_req;
            m_busy = 1'b1;
        end else if (ready) begin
            m_busy = 1'b0;
        end
        accept = v && (mq.size() < DEPTH);
        if (accept) mq.push_back({m_cnt, d});
        if (v && !accept) m_ovf = 1'b1;
        else if (c)       m_ovf = 1'b0;
        m_s2  = m_s1;
        m_s1  = a;
        m_cnt = m_cnt + 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic a, input logic c);
        bus.rx_valid   = v;
        bus.rx_data    = d;
        bus.la_ack_tgl = a;
        bus.la_clr_ovf = c;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge(bus.rx_valid, bus.rx_data, bus.la_ack_tgl, bus.la_clr_ovf);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [DATA_W-1:0] rd, input logic req,
                             input int fill, input logic ovf);
        check({tag, "_rd_data"},  32'(bus.rd_data),    32'(rd));
        check({tag, "_req"},      32'(bus.rd_req_tgl), 32'(req));
        check({tag, "_fill"},     32'(bus.fill_level), 32'(fill));
        check({tag, "_empty"},    32'(bus.empty),      32'(fill == 0));
        check({tag, "_overflow"}, 32'(bus.overflow),   32'(ovf));
    endtask

    task automatic check_model(input string tag);
        check_out(tag, m_rd, m_req, mq.size(), m_ovf);
`ifdef RB_TIMESTAMP_EN
        check({tag, "_tstamp"}, 32'(bus.rd_tstamp), 32'(m_ts));
`endif
    endtask

    // Called just after an active edge; checks that reset takes effect without a clock edge.
    task automatic do_reset(input string tag);
        host_ack = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        check_out({tag, "_rst"}, '0, 1'b0, 0, 1'b0);
`ifdef RB_TIMESTAMP_EN
        check({tag, "_rst_tstamp"}, 32'(bus.rd_tstamp), 32'd0);
`endif
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct packed {
        logic              v;
        logic [DATA_W-1:0] d;
        logic              a;
        logic [DATA_W-1:0] e_rd;
        logic              e_req;
        logic [CW-1:0]     e_fill;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(logic v, logic [DATA_W-1:0] d, logic a,
                                logic [DATA_W-1:0] rd, logic req, int fill);
        vec_t r;
        r.v = v; r.d = d; r.a = a; r.e_rd = rd; r.e_req = req; r.e_fill = CW'(fill);
        return r;
    endfunction

    initial begin
        int vprob;
        drive(1'b0, '0, 1'b0, 1'b0);

        // Three words acked by the host in turn, then an idle-state presentation.
        tbl[0]  = mk(1'b1, 16'd1, 1'b0, 16'd0, 1'b0, 1);
        tbl[1]  = mk(1'b1, 16'd2, 1'b0, 16'd1, 1'b1, 1);
        tbl[2]  = mk(1'b1, 16'd3, 1'b0, 16'd1, 1'b1, 2);
        tbl[3]  = mk(1'b0, 16'd0, 1'b1, 16'd1, 1'b1, 2);
        tbl[4]  = mk(1'b0, 16'd0, 1'b1, 16'd1, 1'b1, 2);
        tbl[5]  = mk(1'b0, 16'd0, 1'b1, 16'd2, 1'b0, 1);
        tbl[6]  = mk(1'b0, 16'd0, 1'b1, 16'd2, 1'b0, 1);
        tbl[7]  = mk(1'b0, 16'd0, 1'b0, 16'd2, 1'b0, 1);
        tbl[8]  = mk(1'b0, 16'd0, 1'b0, 16'd2, 1'b0, 1);
        tbl[9]  = mk(1'b0, 16'd0, 1'b0, 16'd3, 1'b1, 0);
        tbl[10] = mk(1'b0, 16'd0, 1'b1, 16'd3, 1'b1, 0);
        tbl[11] = mk(1'b0, 16'd0, 1'b1, 16'd3, 1'b1, 0);
        tbl[12] = mk(1'b0, 16'd0, 1'b1, 16'd3, 1'b1, 0);
        tbl[13] = mk(1'b1, 16'd4, 1'b1, 16'd3, 1'b1, 1);
        tbl[14] = mk(1'b0, 16'd0, 1'b1, 16'd4, 1'b0, 0);

        #1;
        do_reset("init");

        // Single word written at edge 10, shown at edge 11.
        for (int i = 1; i <= 9; i++) tick();
        drive(1'b1, 16'hA5A5, 1'b0, 1'b0);
        tick();
        check_out("first_wr", 16'h0000, 1'b0, 1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        check_out("first_present", 16'hA5A5, 1'b1, 0, 1'b0);

        do_reset("tbl");
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].a, 1'b0);
            tick();
            check_out($sformatf("tbl%0d", i), tbl[i].e_rd, tbl[i].e_req, int'(tbl[i].e_fill), 1'b0);
        end

        // Overflow, clear, full-with-pop acceptance, and set-beats-clear.
        do_reset("ovf");
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
            tick();
        end
        check_out("ovf_set", 16'h0101, 1'b1, 8, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        check_out("ovf_clr", 16'h0101, 1'b1, 8, 1'b0);
        host_ack = 1'b1;
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        tick();
        drive(1'b1, 16'h0BEE, 1'b1, 1'b0);
        tick();
        check_out("full_pop_push", 16'h0102, 1'b0, 8, 1'b0);
        drive(1'b1, 16'h0DED, 1'b1, 1'b1);
        tick();
        check_out("set_wins", 16'h0102, 1'b0, 8, 1'b1);
        drive(1'b0, '0, host_ack, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (bus.rd_req_tgl != host_ack) host_ack = bus.rd_req_tgl;
            drive(1'b0, '0, host_ack, 1'b0);
            tick();
            check_model($sformatf("drain%0d", i));
        end

        // Reset while words are queued and one is on display.
        do_reset("mid");
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0);
            tick();
        end
        check_out("mid_loaded", 16'h0201, 1'b1, 5, 1'b0);
        do_reset("mid_async");
        drive(1'b1, 16'h3C3C, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        check_out("post_rst", 16'h3C3C, 1'b1, 0, 1'b0);

`ifdef RB_TIMESTAMP_EN
        do_reset("ts");
        for (int i = 1; i <= 100; i++) tick();
        drive(1'b1, 16'h1111, 1'b0, 1'b0);
        tick();
        host_ack = 1'b1;
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        check("ts100_data", 32'(bus.rd_data), 32'h1111);
        check("ts100", 32'(bus.rd_tstamp), 32'd100);
        for (int i = 103; i <= 250; i++) tick();
        drive(1'b1, 16'h2222, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        check("ts250_data", 32'(bus.rd_data), 32'h2222);
        check("ts250", 32'(bus.rd_tstamp), 32'd250);
`endif

        // Randomized traffic against the reference model, alternating light and heavy load.
        do_reset("rand");
        for (int cyc = 0; cyc < 1500; cyc++) begin
            vprob = ((cyc / 300) % 2 == 1) ? 90 : 35;
            if ((bus.rd_req_tgl != host_ack) && ($urandom_range(0, 2) == 0))
                host_ack = bus.rd_req_tgl;
            else if ($urandom_range(0, 59) == 0)
                host_ack = ~host_ack;
            drive($urandom_range(0, 99) < vprob, 16'($urandom), host_ack,
                  $urandom_range(0, 19) == 0);
            tick();
            check_model($sformatf("rand%0d", cyc));
            if (cyc == 777) do_reset("rand_mid");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
